alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the N-bit combinational ALU.
- On a capture strobe it latches the ALU result, or the 2N-bit product, and computes Z/N/C/V status flags.
- Drives a time-multiplexed 4-digit hex seven-segment display for the lab board.
- Isolates the board outputs from combinational ALU glitches while operand switches move.

Parameters:
- N, 4, ALU operand/result width; legal range 2..8 (2N ≤ 16 bits shown on 4 hex digits).
- REFRESH, 50000, clock cycles each digit stays lit; legal ≥ 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- capture  input  1  one-cycle strobe; latch current ALU outputs.
- clear  input  1  drop held value and blank the display.
- mul_sel  input  1  1 = hold multiply product, 0 = hold ALU result.
- op_sum  input  1  addition select, as driven to the ALU.
- op_subt  input  1  subtraction select, as driven to the ALU.
- a  input  N  ALU operand A (sign bit used for V).
- b  input  N  ALU operand B (sign bit used for V).
- result  input  N  ALU muxed result.
- multi_result  input  2N  ALU product.
- carry_sum  input  1  adder carry out.
- carry_subt  input  1  subtractor carry out.
- held_value  output  16  captured value, zero-extended.
- valid  output  1  held_value and flags are meaningful.
- flag_z  output  1  zero.
- flag_n  output  1  negative (MSB of captured width).
- flag_c  output  1  carry / product overflow.
- flag_v  output  1  signed overflow.
- seg  output  7  segments g..a, active-low.
- an  output  4  digit enables, active-low, one-hot; an[0] = least significant digit.

Behaviour:
- Reset (async, rst=1):
  - held_value=0, valid=0, all flags=0.
  - Refresh counter=0, digit index=0.
  - seg=7'h7F, an=4'hF.
  - Takes effect immediately, including mid-scan; no capture occurs while rst=1.
- Capture, on a rising edge with capture=1:
  - Register updates that edge; outputs visible the next cycle (latency 1).
  - valid=1 from the cycle after capture and holds until clear or rst.
- Source select:
  - mul_sel=1: held_value = multi_result (2N bits); width W = 2N.
  - mul_sel=0: held_value = result; width W = N.
  - Upper bits are zero.
- Flags, computed from the captured source:
  - Z = (source == 0).
  - N = source[W-1].
  - mul_sel=1: C = |multi_result[2N-1:N]; V = 0.
  - mul_sel=0 and exactly one of op_sum/op_subt high (add): C = carry_sum; V = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]).
  - Subtract: C = carry_subt; V = (a[N-1]!=b[N-1]) && (result[N-1]!=a[N-1]).
  - Neither or both op_sum/op_subt high: C=0, V=0.
- Clear:
  - On a rising edge with clear=1 and capture=0: valid=0, flags=0, held_value retained.
  - capture=1 and clear=1 in the same cycle: capture wins.
  - Back-to-back captures: each cycle overwrites; no queueing.
- Display scan:
  - Refresh counter counts 0..REFRESH-1, then wraps to 0 and advances the digit index 0→1→2→3→0.
  - The scan runs continuously regardless of valid.
  - Shown digit = held_value[4*idx+3:4*idx]; hex 0–F uses the standard seven-segment encoding.
  - Outputs registered: seg/an change one cycle after the index change.
- Blanking:
  - valid=0: an=4'hF, seg=7'h7F.
  - valid=1: leading-zero digits above the highest nonzero digit are blanked (an bit high).
  - Digit 0 is always lit, so a zero value shows "0".

Test Plan:
- Reset mid-scan:
  - Stimulus: capture value, let the scan reach idx=2, assert rst asynchronously between edges.
  - Response: immediately an=F, seg=7F, valid=0, flags=0; after release the scan restarts at idx=0.
- Add overflow (N=4):
  - Stimulus: a=0111, b=0001, op_sum=1, result=1000, carry_sum=0, capture.
  - Response: next cycle held_value=0x0008, valid=1, Z=0, N=1, C=0, V=1; only an[0] lit, seg="8".
- Subtract zero (N=4):
  - Stimulus: a=0101, b=0101, op_subt=1, result=0000, carry_subt=1, capture.
  - Response: Z=1, N=0, C=1, V=0; an[0] shows "0".
- Multiply (N=4):
  - Stimulus: mul_sel=1, multi_result=8'hE1 (15×15), capture.
  - Response: held_value=0x00E1, C=1, N=1, V=0.
  - Scan with REFRESH=4: an cycles E,D,F(blank),F(blank) with seg "1","E".
- Capture/clear collision:
  - Stimulus: capture=1 and clear=1 same edge, result=0011.
  - Response: valid=1, held_value=3.
  - Next edge clear=1 alone → valid=0, display blank, held_value still 3.
- Both op selects high:
  - Stimulus: op_sum=1, op_subt=1, carry_sum=1, result=1100, capture.
  - Response: C=0, V=0, N=1, Z=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered capture stage behind the combinational ALU: holds result/product with Z/N/C/V flags
// and scans the held value onto a 4-digit active-low hex seven-segment display.
module alu_result_stage #(
    parameter int N       = 4,
    parameter int REFRESH = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             clear,
    input  logic             mul_sel,
    input  logic             op_sum,
    input  logic             op_subt,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     result,
    input  logic [2*N-1:0]   multi_result,
    input  logic             carry_sum,
    input  logic             carry_subt,
    output logic [15:0]      held_value,
    output logic             valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    logic [15:0]   held_q, held_d;
    logic          valid_q, valid_d;
    logic          z_q, n_q, c_q, v_q;
    logic          z_d, n_d, c_d, v_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [15:0]   src;
    logic          src_z, src_n, src_c, src_v;
    logic          is_add, is_sub;
    logic [3:0]    nib;
    logic          lit;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Flags are taken from the captured source only; op selects matter only for the ALU result path.
    always_comb begin
        src    = '0;
        src_n  = 1'b0;
        src_c  = 1'b0;
        src_v  = 1'b0;
        is_add = op_sum & ~op_subt;
        is_sub = op_subt & ~op_sum;
        if (mul_sel) begin
            src[2*N-1:0] = multi_result;
            src_n        = multi_result[2*N-1];
            src_c        = |multi_result[2*N-1:N];
        end else begin
            src[N-1:0] = result;
            src_n      = result[N-1];
            if (is_add) begin
                src_c = carry_sum;
                src_v = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end else if (is_sub) begin
                src_c = carry_subt;
                src_v = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
        end
        src_z = (src == 16'd0);
    end

    always_comb begin
        held_d  = held_q;
        valid_d = valid_q;
        z_d = z_q;  n_d = n_q;  c_d = c_q;  v_d = v_q;
        if (capture) begin
            held_d  = src;
            valid_d = 1'b1;
            z_d = src_z;  n_d = src_n;  c_d = src_c;  v_d = src_v;
        end else if (clear) begin
            valid_d = 1'b0;
            z_d = 1'b0;  n_d = 1'b0;  c_d = 1'b0;  v_d = 1'b0;
        end
    end

    // A digit is lit if it is digit 0 or any nibble at or above it is nonzero.
    always_comb begin
        nib   = held_q[{idx_q, 2'b00} +: 4];
        lit   = (idx_q == 2'd0) || ((held_q >> {idx_q, 2'b00}) != 16'd0);
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (valid_q && lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= '0;
            valid_q <= 1'b0;
            z_q <= 1'b0;  n_q <= 1'b0;  c_q <= 1'b0;  v_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            held_q  <= held_d;
            valid_q <= valid_d;
            z_q <= z_d;  n_q <= n_d;  c_q <= c_d;  v_q <= v_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            if (cnt_q == CW'(REFRESH - 1)) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign held_value = held_q;
    assign valid      = valid_q;
    assign flag_z     = z_q;
    assign flag_n     = n_q;
    assign flag_c     = c_q;
    assign flag_v     = v_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule
